// File: rtl/inst_mem_bank.sv
// Byte-addressed instruction memory with per-lane writes, registered reads and
// a self-timed zeroing sweep that runs after reset or on a clear request.
module inst_mem_bank #(
  parameter int                  NB_DATA    = 32,
  parameter int                  NBYTE      = 8,
  parameter int                  N_ELEMENTS = 256,
  parameter logic [NB_DATA-1:0]  HALT_WORD  = 32'hfc000000,
  localparam int                 IDX_W      = $clog2(N_ELEMENTS)
) (
  input  logic                       clock_i,
  input  logic                       reset_i,
  input  logic                       clear_i,
  input  logic                       en_write_i,
  input  logic [NB_DATA/NBYTE-1:0]   byte_en_i,
  input  logic [NB_DATA-1:0]         addr_i_write,
  input  logic [NB_DATA-1:0]         data_i,
  input  logic                       en_read_i,
  input  logic [NB_DATA-1:0]         addr_i_read,
  output logic [NB_DATA-1:0]         data_o,
  output logic                       valid_o,
  output logic                       rd_err_o,
  output logic                       wr_err_o,
  output logic                       busy_o,
  output logic                       halt_o,
  output logic [IDX_W:0]             n_words_o
);

  // state    | meaning
  // ST_CLEAR | zeroing word idx_q each cycle; accesses ignored
  // ST_IDLE  | normal read/write access

  localparam int NLANES = NB_DATA / NBYTE;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_ELEMENTS - 1);

  typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [NB_DATA-1:0]   data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 rd_err_q, rd_err_d;
  logic                 wr_err_q, wr_err_d;
  logic                 halt_q, halt_d;
  logic [IDX_W:0]       n_words_q, n_words_d;

  logic [NB_DATA-1:0]   mem_q [N_ELEMENTS];
  logic                 mem_we;
  logic [IDX_W-1:0]     mem_widx;
  logic [NB_DATA-1:0]   mem_wdata;

  logic [IDX_W-1:0]     wr_idx, rd_idx;
  logic                 wr_legal, rd_legal;
  logic [NB_DATA-1:0]   wr_merged;
  logic [IDX_W:0]       wr_count;

  assign wr_idx   = addr_i_write[IDX_W+1:2];
  assign rd_idx   = addr_i_read[IDX_W+1:2];
  assign wr_legal = (addr_i_write[1:0] == 2'b00) && (addr_i_write[NB_DATA-1:IDX_W+2] == '0);
  assign rd_legal = (addr_i_read[1:0] == 2'b00) && (addr_i_read[NB_DATA-1:IDX_W+2] == '0);
  assign wr_count = {1'b0, wr_idx} + (IDX_W+1)'(1);

  // Disabled lanes keep the stored bytes.
  always_comb begin
    wr_merged = mem_q[wr_idx];
    for (int k = 0; k < NLANES; k++) begin
      if (byte_en_i[k]) wr_merged[k*NBYTE +: NBYTE] = data_i[k*NBYTE +: NBYTE];
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    rd_err_d  = rd_err_q;
    wr_err_d  = wr_err_q;
    halt_d    = halt_q;
    n_words_d = n_words_q;
    mem_we    = 1'b0;
    mem_widx  = idx_q;
    mem_wdata = '0;
    case (state_q)
      ST_CLEAR: begin
        mem_we = 1'b1;
        idx_d  = idx_q + IDX_W'(1);
        if (idx_q == IDX_LAST) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (clear_i) begin
          state_d   = ST_CLEAR;
          idx_d     = '0;
          halt_d    = 1'b0;
          wr_err_d  = 1'b0;
          n_words_d = '0;
        end else begin
          // Read samples mem_q before this edge's write lands: read-first.
          if (en_read_i) begin
            valid_d = 1'b1;
            if (rd_legal) begin
              data_d   = mem_q[rd_idx];
              rd_err_d = 1'b0;
            end else begin
              data_d   = '0;
              rd_err_d = 1'b1;
            end
          end
          if (en_write_i) begin
            if (wr_legal) begin
              mem_we    = 1'b1;
              mem_widx  = wr_idx;
              mem_wdata = wr_merged;
              if (wr_count > n_words_q) n_words_d = wr_count;
              if ((&byte_en_i) && (data_i == HALT_WORD)) halt_d = 1'b1;
            end else begin
              wr_err_d = 1'b1;
            end
          end
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q   <= ST_CLEAR;
      idx_q     <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      rd_err_q  <= 1'b0;
      wr_err_q  <= 1'b0;
      halt_q    <= 1'b0;
      n_words_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      rd_err_q  <= rd_err_d;
      wr_err_q  <= wr_err_d;
      halt_q    <= halt_d;
      n_words_q <= n_words_d;
    end
  end

  always_ff @(posedge clock_i) begin
    if (mem_we) mem_q[mem_widx] <= mem_wdata;
  end

  assign data_o    = data_q;
  assign valid_o   = valid_q;
  assign rd_err_o  = rd_err_q;
  assign wr_err_o  = wr_err_q;
  assign busy_o    = (state_q == ST_CLEAR);
  assign halt_o    = halt_q;
  assign n_words_o = n_words_q;

endmodule
